// File: rtl/seq_restoring_div_8bit.sv
// Sequential unsigned restoring divider: one shift/compare/subtract step per clock.
// A start/busy/done handshake is used; divide-by-zero completes without iterating.
module seq_restoring_div_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_v;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH:0]   w_t;
  logic             w_ge;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;

  // Nine-bit compare/subtract keeps the borrow out of the partial remainder.
  always_comb begin
    w_t      = {r_r[WIDTH-1:0], r_d[WIDTH-1]};
    w_ge     = (w_t >= {1'b0, r_v});
    w_diff   = w_t - {1'b0, r_v};
    w_r_next = w_ge ? w_diff : w_t;
    w_q_next = {r_q[WIDTH-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_d         <= '0;
      r_v         <= '0;
      r_r         <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (divisor != '0) begin
              r_d     <= dividend;
              r_v     <= divisor;
              r_r     <= '0;
              r_q     <= '0;
              r_cnt   <= CW'(WIDTH - 1);
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end else begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_d <= {r_d[WIDTH-2:0], 1'b0};
          r_r <= w_r_next;
          r_q <= w_q_next;
          if (r_cnt == '0) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next[WIDTH-1:0];
            r_dbz       <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule
